// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for a weight-stationary NxN systolic array: loads each K-tile's weights,
// streams skewed activation vectors, strobes column outputs, drains, and pulses done.
module sa_tile_ctrl #(
  parameter int N        = 16,
  parameter int CNT_W    = 16,
  parameter int WBUF_LAT = 1,
  parameter int OUT_LAT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_m,
  input  logic [CNT_W-1:0] cfg_tiles,
  input  logic             act_avail,
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [CNT_W-1:0] w_rd_addr,
  output logic             sa_load_w,
  output logic             act_rd_en,
  output logic [CNT_W-1:0] act_rd_addr,
  output logic [N-1:0]     row_valid,
  output logic             sa_valid_in,
  output logic [N-1:0]     out_col_en,
  output logic             out_accum
);
  localparam int DL = OUT_LAT + N;
  localparam logic [7:0] WLAST = 8'(WBUF_LAT - 1);
  localparam logic [CNT_W:0] ONE_W = (CNT_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_WWAIT, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] m_q, m_d, tiles_q, tiles_d, tile_q, tile_d, vec_q, vec_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [DL-1:0]    dl_q, dl_d;
  logic             issue, wlast, last_vec, last_tile;

  assign issue     = (state_q == S_STREAM) && act_avail && (vec_q < m_q);
  assign wlast     = (wcnt_q == WLAST);
  assign last_vec  = (({1'b0, vec_q} + ONE_W) == {1'b0, m_q});
  assign last_tile = (({1'b0, tile_q} + ONE_W) >= {1'b0, tiles_q});
  // One shift line carries the issue bit: low taps skew the rows, high taps strobe the columns.
  assign dl_d      = {dl_q[DL-2:0], issue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      tiles_q <= '0;
      tile_q  <= '0;
      vec_q   <= '0;
      wcnt_q  <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      tiles_q <= tiles_d;
      tile_q  <= tile_d;
      vec_q   <= vec_d;
      wcnt_q  <= wcnt_d;
      dl_q    <= dl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    tiles_d = tiles_q;
    tile_d  = tile_q;
    vec_d   = vec_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = cfg_m;
          tiles_d = cfg_tiles;
          tile_d  = '0;
          vec_d   = '0;
          state_d = (cfg_m == '0 || cfg_tiles == '0) ? S_FIN : S_WLOAD;
        end
      end
      S_WLOAD: begin
        wcnt_d  = '0;
        state_d = S_WWAIT;
      end
      S_WWAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (wlast) begin
          vec_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (issue) begin
          vec_d = vec_q + CNT_W'(1);
          if (last_vec) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave only once the line will be empty, so the next weight load never meets live psums.
        if (dl_d == '0) begin
          if (last_tile) begin
            state_d = S_FIN;
          end else begin
            tile_d  = tile_q + CNT_W'(1);
            state_d = S_WLOAD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FIN);
    w_rd_en     = (state_q == S_WLOAD);
    w_rd_addr   = (state_q == S_WLOAD) ? tile_q : '0;
    sa_load_w   = (state_q == S_WWAIT) && wlast;
    act_rd_en   = issue;
    act_rd_addr = issue ? vec_q : '0;
    out_accum   = (state_q != S_IDLE) && (tile_q != '0);
  end

  assign row_valid   = dl_q[N-1:0];
  assign sa_valid_in = dl_q[0];
  assign out_col_en  = dl_q[DL-1:OUT_LAT];

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Scoreboard bench for sa_tile_ctrl: directed jobs push expected strobe timings, a negedge monitor pops and compares.
module tb_sa_tile_ctrl;
  localparam int N = 16;
  localparam int CNT_W = 16;
  localparam int OUT_LAT = 16;
  localparam int DL = OUT_LAT + N;

  typedef struct { int t; int v; } ev_t;

  logic clk, rst_n, start, act_avail;
  logic [CNT_W-1:0] cfg_m, cfg_tiles;
  logic busy, done, w_rd_en, sa_load_w, act_rd_en, sa_valid_in, out_accum;
  logic [CNT_W-1:0] w_rd_addr, act_rd_addr;
  logic [N-1:0] row_valid, out_col_en;

  sa_tile_ctrl #(.N(N), .CNT_W(CNT_W), .WBUF_LAT(1), .OUT_LAT(OUT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_tiles(cfg_tiles),
    .act_avail(act_avail), .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .sa_load_w(sa_load_w), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .row_valid(row_valid), .sa_valid_in(sa_valid_in), .out_col_en(out_col_en), .out_accum(out_accum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = -100000;
  int done_rel = -1;
  bit free_run = 1'b0;
  int done_cnt = 0;
  int done_at = 0;
  int act_cnt = 0;
  int col_cnt [N];
  logic [DL-1:0] act_hist = '0;

  ev_t w_q[$], act_q[$], c0_q[$];
  int  ld_q[$], c15_q[$], done_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle skew/strobe properties plus queue-driven event timing.
  always @(negedge clk) begin
    int rel;
    ev_t e;
    int t;
    rel = cyc - t0;
    if (!rst_n) begin
      act_hist = '0;
    end else begin
      chk("row_valid", row_valid, act_hist[N-1:0]);
      chk("sa_valid_in", sa_valid_in, act_hist[0]);
      chk("out_col_en", out_col_en, act_hist[DL-1:OUT_LAT]);
      act_hist = {act_hist[DL-2:0], act_rd_en};
      for (int j = 0; j < N; j++) col_cnt[j] += int'(out_col_en[j]);
      if (act_rd_en) act_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (!free_run) begin
        chk("busy", busy, (rel >= 1 && rel <= done_rel));
        if (w_rd_en) begin
          if (w_q.size() == 0) chk("w_rd_en_extra", 1, 0);
          else begin
            e = w_q.pop_front();
            chk("w_rd_en_cyc", rel, e.t);
            chk("w_rd_addr", w_rd_addr, e.v);
          end
        end
        if (sa_load_w) begin
          if (ld_q.size() == 0) chk("sa_load_w_extra", 1, 0);
          else begin t = ld_q.pop_front(); chk("sa_load_w_cyc", rel, t); end
        end
        if (act_rd_en) begin
          if (act_q.size() == 0) chk("act_rd_en_extra", 1, 0);
          else begin
            e = act_q.pop_front();
            chk("act_rd_en_cyc", rel, e.t);
            chk("act_rd_addr", act_rd_addr, e.v);
          end
        end
        if (out_col_en[0]) begin
          if (c0_q.size() == 0) chk("col0_extra", 1, 0);
          else begin
            e = c0_q.pop_front();
            chk("col0_cyc", rel, e.t);
            chk("out_accum", out_accum, e.v);
          end
        end
        if (out_col_en[N-1]) begin
          if (c15_q.size() == 0) chk("col15_extra", 1, 0);
          else begin t = c15_q.pop_front(); chk("col15_cyc", rel, t); end
        end
        if (done) begin
          if (done_q.size() == 0) chk("done_extra", 1, 0);
          else begin t = done_q.pop_front(); chk("done_cyc", rel, t); end
        end
      end
    end
  end

  // Expected strobes of one tile whose WLOAD cycle is b; a stall of hole_len cycles precedes vector hole_at.
  // Issue at t -> row_valid[0] t+1, out_col_en[0] t+17, out_col_en[15] t+32, next WLOAD/FIN last+33.
  task automatic push_tile(input int b, input int tile, input int m, input int hole_at,
                           input int hole_len, output int nb);
    int t;
    t = b + 2;
    w_q.push_back('{b, tile});
    ld_q.push_back(b + 1);
    for (int k = 0; k < m; k++) begin
      if (k == hole_at) t += hole_len;
      act_q.push_back('{t, k});
      c0_q.push_back('{t + 17, (tile != 0) ? 1 : 0});
      c15_q.push_back(t + 32);
      t++;
    end
    nb = t + 32;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_rd_en"}, w_rd_en, 0);
    chk({tag, "_sa_load_w"}, sa_load_w, 0);
    chk({tag, "_act_rd_en"}, act_rd_en, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_out_col_en"}, out_col_en, 0);
    chk({tag, "_out_accum"}, out_accum, 0);
  endtask

  task automatic run_job(input int m, input int tiles, input int hole_at, input int hole_len,
                         input int pulse_at, input int rst_at, input bit rnd);
    int b;
    int rel;
    bit finished;
    @(posedge clk); #1;
    free_run = rnd;
    done_cnt = 0;
    act_cnt  = 0;
    for (int j = 0; j < N; j++) col_cnt[j] = 0;
    t0 = cyc;
    done_rel = -1;
    if (!rnd) begin
      if (m == 0 || tiles == 0) begin
        done_q.push_back(1);
        done_rel = 1;
      end else begin
        b = 1;
        for (int k = 0; k < tiles; k++)
          push_tile(b, k, m, (k == 0) ? hole_at : -1, hole_len, b);
        done_q.push_back(b);
        done_rel = b;
      end
    end
    cfg_m = CNT_W'(m);
    cfg_tiles = CNT_W'(tiles);
    start = 1'b1;
    act_avail = 1'b1;
    finished = 1'b0;
    for (int k = 0; k < 6000 && !finished; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = (rel == pulse_at);
      cfg_m = start ? 16'd7 : CNT_W'($urandom);
      cfg_tiles = start ? 16'd7 : CNT_W'($urandom);
      if (rnd) act_avail = 1'($urandom_range(0, 1));
      else act_avail = !(hole_len > 0 && rel >= 3 + hole_at && rel < 3 + hole_at + hole_len);
      if (rel == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        w_q.delete(); act_q.delete(); c0_q.delete();
        ld_q.delete(); c15_q.delete(); done_q.delete();
        done_rel = -1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        return;
      end
      if (done_cnt > 0 && cyc >= done_at + 4) finished = 1'b1;
    end
    start = 1'b0;
    act_avail = 1'b0;
    if (!finished) chk("job_timeout", 0, 1);
    chk("done_count", done_cnt, 1);
    chk("act_rd_count", act_cnt, m * tiles);
    for (int j = 0; j < N; j++) chk($sformatf("col%0d_count", j), col_cnt[j], m * tiles);
    if (!rnd) begin
      chk("w_q_left", w_q.size(), 0);
      chk("ld_q_left", ld_q.size(), 0);
      chk("act_q_left", act_q.size(), 0);
      chk("c0_q_left", c0_q.size(), 0);
      chk("c15_q_left", c15_q.size(), 0);
      chk("done_q_left", done_q.size(), 0);
    end
    free_run = 1'b0;
    done_rel = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_m = '0;
    cfg_tiles = '0;
    act_avail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(4, 1, -1, 0, -1, -1, 1'b0);   // w@1 ld@2 act 3..6 col0 20..23 col15 35..38 done@39
    run_job(3, 3, -1, 0, -1, -1, 1'b0);   // three tiles, accumulate on tiles 1 and 2
    run_job(5, 1, 2, 2, -1, -1, 1'b0);    // addr 0,1 | 2-cycle stall | 2,3,4
    run_job(0, 2, -1, 0, -1, -1, 1'b0);   // empty job: done one cycle after start
    run_job(3, 0, -1, 0, -1, -1, 1'b0);
    run_job(4, 1, -1, 0, 10, -1, 1'b0);   // start pulsed while busy is ignored
    run_job(4, 1, -1, 0, -1, 5, 1'b0);    // reset mid-stream discards the job
    run_job(4, 1, -1, 0, -1, -1, 1'b0);   // identical timing after that reset
    for (int r = 0; r < 2; r++)
      run_job($urandom_range(1, 64), $urandom_range(1, 4), -1, 0, -1, -1, 1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
